// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the loadable down-counter timer.
package down_counter_timer_pkg;

   // Default counter width, common with the free-running up-counter.
   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter: counts a loaded value to zero on enabled cycles,
// emits a one-cycle Done pulse, and optionally reloads for periodic ticks.
module down_counter_timer
   import down_counter_timer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   input  logic             Start,
   input  logic             Enable,
   input  logic             AutoReload,
   input  logic             Abort,
   output logic [WIDTH-1:0] Q,
   output logic             Busy,
   output logic             Done,
   output logic             Zero
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_e           state_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] reload_q;
   logic             done_q;

   // State, count, reload value and Done pulse; priority Reset > Abort > Load > Start > Enable.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= ST_IDLE;
         q_q      <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (Abort) begin
            // Stop where we are; Q is kept so a later Start resumes from it.
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (Load) begin
                     q_q      <= D;
                     reload_q <= D;
                  end else if (Start && (q_q != '0)) begin
                     // The Start edge itself never decrements.
                     state_q <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (Enable) begin
                     if (q_q == ONE) begin
                        done_q <= 1'b1;
                        if (AutoReload) begin
                           q_q <= reload_q;
                        end else begin
                           q_q     <= '0;
                           state_q <= ST_IDLE;
                        end
                     end else if (q_q != '0) begin
                        // Q == 0 in RUN is unreachable; guard keeps it from wrapping.
                        q_q <= q_q - ONE;
                     end
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign Q    = q_q;
   assign Busy = (state_q == ST_RUN);
   assign Done = done_q;

   // Zero is a plain decode of the registered count.
   assign Zero = (q_q == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: the driver pushes the hand-computed
// post-edge outputs, a negedge monitor pops and compares them.
module tb_down_counter_timer;

   localparam int W = 4;

   logic         Clk = 1'b0;
   logic         Reset = 1'b0, Load = 1'b0, Start = 1'b0, Enable = 1'b0;
   logic         AutoReload = 1'b0, Abort = 1'b0;
   logic [W-1:0] D = '0;
   logic [W-1:0] Q;
   logic         Busy, Done, Zero;

   typedef struct {
      logic [W-1:0] q;
      logic         busy;
      logic         done;
      logic         zero;
      string        name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   down_counter_timer #(.WIDTH(W)) dut (
      .Clk(Clk), .Reset(Reset), .Load(Load), .D(D), .Start(Start),
      .Enable(Enable), .AutoReload(AutoReload), .Abort(Abort),
      .Q(Q), .Busy(Busy), .Done(Done), .Zero(Zero)
   );

   always #5 Clk = ~Clk;

   // Monitor: outputs are presented every cycle; compare against the oldest expectation.
   always @(negedge Clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (Q === e.q && Busy === e.busy && Done === e.done && Zero === e.zero)
            passed++;
         else
            $display("FAIL %s: got Q=%0d Busy=%b Done=%b Zero=%b, want Q=%0d Busy=%b Done=%b Zero=%b",
                     e.name, Q, Busy, Done, Zero, e.q, e.busy, e.done, e.zero);
      end
   end

   // One clock edge with the currently driven inputs; pulse inputs are cleared afterwards.
   task automatic tick(input int eq, input bit eb, input bit ed, input string nm);
      exp_t e;
      @(posedge Clk);
      e.q = eq[W-1:0]; e.busy = eb; e.done = ed; e.zero = (eq == 0); e.name = nm;
      sb.push_back(e);
      @(negedge Clk);
      Reset = 1'b0; Load = 1'b0; Start = 1'b0; Abort = 1'b0;
   endtask

   initial begin
      @(negedge Clk);
      Reset = 1'b1;                      tick(0, 0, 0, "reset");

      // 1: single countdown from 5
      Load = 1'b1; D = 4'd5;             tick(5, 0, 0, "t1_load");
      Start = 1'b1; Enable = 1'b1;       tick(5, 1, 0, "t1_start");
      tick(4, 1, 0, "t1_c4"); tick(3, 1, 0, "t1_c3"); tick(2, 1, 0, "t1_c2");
      tick(1, 1, 0, "t1_c1"); tick(0, 0, 1, "t1_done"); tick(0, 0, 0, "t1_after");

      // 2: auto-reload period 3, then stop by clearing AutoReload
      Enable = 1'b0; AutoReload = 1'b1;
      Load = 1'b1; D = 4'd3;             tick(3, 0, 0, "t2_load");
      Start = 1'b1; Enable = 1'b1;       tick(3, 1, 0, "t2_start");
      tick(2, 1, 0, "t2_a2"); tick(1, 1, 0, "t2_a1"); tick(3, 1, 1, "t2_reload1");
      tick(2, 1, 0, "t2_b2"); tick(1, 1, 0, "t2_b1"); tick(3, 1, 1, "t2_reload2");
      tick(2, 1, 0, "t2_c2");
      AutoReload = 1'b0;                 tick(1, 1, 0, "t2_c1");
      tick(0, 0, 1, "t2_stop"); tick(0, 0, 0, "t2_after");

      // 3: gated Enable
      Enable = 1'b0;
      Load = 1'b1; D = 4'd2;             tick(2, 0, 0, "t3_load");
      Start = 1'b1;                      tick(2, 1, 0, "t3_start");
      Enable = 1'b0;                     tick(2, 1, 0, "t3_hold1");
      Enable = 1'b1;                     tick(1, 1, 0, "t3_dec1");
      Enable = 1'b0;                     tick(1, 1, 0, "t3_hold2");
      Enable = 1'b1;                     tick(0, 0, 1, "t3_done");
      tick(0, 0, 0, "t3_after");

      // 4: abort at Q=2, resume, reload register still 6
      Load = 1'b1; D = 4'd6;             tick(6, 0, 0, "t4_load");
      Start = 1'b1;                      tick(6, 1, 0, "t4_start");
      tick(5, 1, 0, "t4_c5"); tick(4, 1, 0, "t4_c4"); tick(3, 1, 0, "t4_c3");
      tick(2, 1, 0, "t4_c2");
      Abort = 1'b1;                      tick(2, 0, 0, "t4_abort");
      tick(2, 0, 0, "t4_idle");
      AutoReload = 1'b1; Start = 1'b1;   tick(2, 1, 0, "t4_resume");
      tick(1, 1, 0, "t4_r1"); tick(6, 1, 1, "t4_reload6"); tick(5, 1, 0, "t4_r5");
      Abort = 1'b1;                      tick(5, 0, 0, "t4_abort2");
      AutoReload = 1'b0;
      Abort = 1'b1; Load = 1'b1; D = 4'd4; tick(5, 0, 0, "abort_beats_load");

      // 5: boundaries
      Load = 1'b1; D = 4'd0;             tick(0, 0, 0, "t5_load0");
      Start = 1'b1;                      tick(0, 0, 0, "t5_start0");
      tick(0, 0, 0, "t5_idle0");
      Load = 1'b1; D = 4'd15;            tick(15, 0, 0, "t5_load15");
      Start = 1'b1;                      tick(15, 1, 0, "t5_start15");
      for (int k = 14; k >= 1; k--) begin
         if (k == 10) begin Load = 1'b1; D = 4'd9; Start = 1'b1; end
         tick(k, 1, 0, "t5_count15");
      end
      tick(0, 0, 1, "t5_done15");
      Load = 1'b1; Start = 1'b1; D = 4'd7; tick(7, 0, 0, "t5_load_start");
      tick(7, 0, 0, "t5_still_idle");

      // 6: reset mid-run, reset at terminal count, sub-cycle reset glitch
      Start = 1'b1;                      tick(7, 1, 0, "t6_start7");
      Reset = 1'b1;                      tick(0, 0, 0, "t6_reset_run");
      Load = 1'b1; D = 4'd2;             tick(2, 0, 0, "t6_load2");
      Start = 1'b1;                      tick(2, 1, 0, "t6_start2");
      tick(1, 1, 0, "t6_c1");
      Reset = 1'b1;                      tick(0, 0, 0, "t6_reset_tc");
      tick(0, 0, 0, "t6_no_done");
      Load = 1'b1; D = 4'd3;             tick(3, 0, 0, "t6_load3");
      Start = 1'b1;                      tick(3, 1, 0, "t6_start3");
      #2 Reset = 1'b1; #1 Reset = 1'b0;  tick(2, 1, 0, "t6_glitch");
      tick(1, 1, 0, "t6_g1"); tick(0, 0, 1, "t6_gdone");

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge Clk);
      if (sb.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable down-counter: the count-down complement of the team's free-running 4-bit up-counter.
- Counts a loaded value down to zero on enabled cycles, then emits a one-cycle Done pulse.
- Optional auto-reload makes it a periodic tick generator.
- Used as a programmable delay/timeout for shift-register and sequencing blocks.

Parameters:
WIDTH, 4, counter width in bits; count range 0..2^WIDTH-1

Ports:
Clk  input  1  clock; all state changes on rising edge
Reset  input  1  synchronous, active-high reset
Load  input  1  capture D into Q and the reload register (IDLE only)
D  input  WIDTH  load value
Start  input  1  begin counting (IDLE only, Q != 0)
Enable  input  1  count-enable tick; Q decrements only when Enable=1 in RUN
AutoReload  input  1  sampled at terminal count; 1 = reload and keep running
Abort  input  1  stop counting, hold Q, no Done
Q  output  WIDTH  current count (registered)
Busy  output  1  1 while state = RUN (registered)
Done  output  1  one-cycle pulse, registered, asserted the cycle after terminal count
Zero  output  1  combinational Q == 0

Behaviour:
- Reset (synchronous, sampled on the Clk edge):
  - Q = 0, reload register = 0, state = IDLE, Busy = 0, Done = 0.
  - Reset overrides every other input, including in-flight Done generation.
- Priority on any edge: Reset > Abort > Load > Start > Enable.
- States:
  - IDLE:
    - Load: Q <= D and reload register <= D.
    - Start with Q != 0: go to RUN, Busy <= 1.
    - Start with Q == 0: ignored; no Done, stay IDLE.
    - Load and Start in the same cycle: Load wins, Start is dropped.
  - RUN:
    - Enable=1 and Q > 1: Q <= Q-1.
    - Enable=0: Q holds.
    - Terminal count (Enable=1 and Q == 1):
      - AutoReload=1: Q <= reload register, stay RUN.
      - AutoReload=0: Q <= 0, go to IDLE, Busy <= 0.
      - In both cases Done <= 1 for exactly one cycle.
    - Abort: go to IDLE, Q holds its current value, Busy <= 0, no Done.
    - Load and Start are ignored while in RUN.
- Done:
  - Is 0 in every cycle other than the one after a terminal count.
  - A back-to-back pulse is allowed only with a reload value of 1 and Enable held high.
- Latency:
  - The Start edge does not decrement.
  - With Enable held high, Done is high in the N-th cycle after the Start edge, where N is the loaded value.
- No wrap-around: Q never decrements from 0 to 2^WIDTH-1. Q = 0 in RUN is unreachable.
- Auto-reload period = reload value in enabled cycles.
- Reload register changes only on Load or Reset. Abort followed by Start resumes from the held Q, not from the reload value.

Decomposition:
- Shared package/header holds:
  - State encodings: ST_IDLE = 1'b0, ST_RUN = 1'b1.
  - Default WIDTH constant, shared with the up-counter.
- No sub-module. Single always block for state/Q/reload/Done, plus a continuous assign for Zero.

Test Plan:
1. Reset; Load D=5; Start; Enable=1 held → Q goes 5,4,3,2,1,0 over the 5 cycles after Start; Done=1 only in the cycle Q=0; Busy falls at the same time; Zero=1.
2. Load D=3; AutoReload=1; Start; Enable=1 → Q cycles 3,2,1,3,2,1...; Done pulses every 3 cycles; Busy stays 1; clearing AutoReload before the next terminal count → stops at Q=0.
3. Load D=2; Start; Enable alternating 1/0 → Q holds on Enable=0 cycles; Done arrives 4 cycles after Start; exactly one pulse.
4. Load D=6; Start; Abort when Q=2 → Busy=0, Q=2, no Done. Then Start → Done 2 enabled cycles later; reload register still 6 (verify with AutoReload=1 → Q reloads to 6).
5. Boundaries:
   - Load D=0, Start → stays IDLE, Busy=0, no Done.
   - Load D=15, Start → Done after 15 cycles.
   - Load D=9 pulsed while in RUN → ignored.
   - Load+Start in the same IDLE cycle → Q=D, state IDLE.
6. Reset mid-run:
   - Reset asserted at Q=7 → next edge Q=0, Busy=0, Done=0.
   - Reset in the terminal-count cycle → no Done pulse.
   - Reset pulse shorter than one edge window (between edges) → no effect (synchronous).
